// File: rtl/dmem_store_queue_pkg.sv
// Shared size encoding and helpers for the data-memory store queue.
package dmem_store_queue_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Size code 3 has no meaning for a store, so it is reported as misaligned and dropped.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~addr_lo[0];
            SZ_WORD: return (addr_lo == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 4'b0001;
            SZ_HALF: return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_store_queue_fwd_sel.sv
// Per-byte priority select for store-to-load forwarding; entry 0 is the youngest.
module dmem_store_queue_fwd_sel #(
    parameter int unsigned N_ENTRIES  = 4,
    parameter int unsigned NB         = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [N_ENTRIES-1:0]                 i_match,
    input  logic [N_ENTRIES-1:0][NB-1:0]         i_mask,
    input  logic [N_ENTRIES-1:0][DATA_WIDTH-1:0] i_data,
    output logic [NB-1:0]                        o_found,
    output logic [DATA_WIDTH-1:0]                o_data
);

    always_comb begin
        o_found = '0;
        o_data  = '0;
        // Walk oldest to youngest so a younger match overrides an older one.
        for (int k = N_ENTRIES - 1; k >= 0; k--) begin
            for (int b = 0; b < NB; b++) begin
                if (i_match[k] && i_mask[k][b]) begin
                    o_found[b]        = 1'b1;
                    o_data[b*8 +: 8]  = i_data[k][b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_store_queue.sv
// In-order store queue with byte-granular load forwarding and a valid/ready drain port.
// Optional store coalescing into the youngest entry is enabled by defining STQ_COALESCE_EN.
module dmem_store_queue
    import dmem_store_queue_pkg::*;
#(
    parameter int unsigned N_ENTRIES  = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned NB        = DATA_WIDTH / 8,
    localparam int unsigned CNT_W     = $clog2(N_ENTRIES) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_st_valid,
    input  logic [ADDR_WIDTH-1:0] i_st_addr,
    input  logic [1:0]            i_st_size,
    input  logic [DATA_WIDTH-1:0] i_st_data,
    output logic                  o_st_ready,
    output logic                  o_st_misalign,
    input  logic                  i_ld_valid,
    input  logic [ADDR_WIDTH-1:0] i_ld_addr,
    input  logic [1:0]            i_ld_size,
    output logic                  o_ld_hit,
    output logic                  o_ld_partial,
    output logic [DATA_WIDTH-1:0] o_ld_data,
    output logic                  o_dr_valid,
    output logic [ADDR_WIDTH-1:0] o_dr_addr,
    output logic [NB-1:0]         o_dr_mask,
    output logic [DATA_WIDTH-1:0] o_dr_data,
    input  logic                  i_dr_ready,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned PTR_W = $clog2(N_ENTRIES);
    localparam int unsigned WA_W  = ADDR_WIDTH - OFF_W;
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef struct packed {
        logic                  valid;
        logic [WA_W-1:0]       word_addr;
        logic [NB-1:0]         mask;
        logic [DATA_WIDTH-1:0] data;
    } stq_entry_t;

    stq_entry_t       r_q [N_ENTRIES];
    logic [PTR_W:0]   r_head, r_tail;

    logic [PTR_W-1:0] w_head_idx, w_tail_idx, w_last_idx;
    logic [CNT_W-1:0] w_count;
    logic             w_full, w_empty, w_pop, w_coal, w_aligned, w_push, w_alloc, w_merge;
    logic [OFF_W-1:0] w_st_off, w_ld_off;
    logic [WA_W-1:0]  w_st_waddr, w_ld_waddr;
    logic [NB-1:0]    w_st_mask, w_ld_mask, w_found, w_cov;
    logic [DATA_WIDTH-1:0] w_st_bits, w_ld_bits, w_st_lanes, w_merged, w_fwd_data;
    logic             w_all;
    logic [N_ENTRIES-1:0]                 w_ord_match;
    logic [N_ENTRIES-1:0][NB-1:0]         w_ord_mask;
    logic [N_ENTRIES-1:0][DATA_WIDTH-1:0] w_ord_data;

    assign w_head_idx = r_head[PTR_W-1:0];
    assign w_tail_idx = r_tail[PTR_W-1:0];
    assign w_last_idx = w_tail_idx - PTR_W'(1);
    assign w_count    = r_tail - r_head;
    assign w_full     = (r_head[PTR_W] != r_tail[PTR_W]) && (w_head_idx == w_tail_idx);
    assign w_empty    = (r_head == r_tail);

    assign w_st_off   = i_st_addr[OFF_W-1:0];
    assign w_st_waddr = i_st_addr[ADDR_WIDTH-1:OFF_W];
    assign w_st_mask  = NB'(size_bytes(i_st_size)) << w_st_off;
    assign w_ld_off   = i_ld_addr[OFF_W-1:0];
    assign w_ld_waddr = i_ld_addr[ADDR_WIDTH-1:OFF_W];
    assign w_ld_mask  = NB'(size_bytes(i_ld_size)) << w_ld_off;

    for (genvar b = 0; b < NB; b++) begin : g_lane
        assign w_st_bits[b*8 +: 8] = {8{w_st_mask[b]}};
        assign w_ld_bits[b*8 +: 8] = {8{w_ld_mask[b]}};
    end

    assign w_st_lanes = (i_st_data << {w_st_off, 3'b000}) & w_st_bits;
    assign w_merged   = (r_q[w_last_idx].data & ~w_st_bits) | w_st_lanes;

    assign o_dr_valid = r_q[w_head_idx].valid;
    assign w_pop      = o_dr_valid && i_dr_ready;

`ifdef STQ_COALESCE_EN
    // The youngest entry cannot be merged into while it is leaving the queue.
    assign w_coal = !w_empty && r_q[w_last_idx].valid
                    && (r_q[w_last_idx].word_addr == w_st_waddr)
                    && !(w_pop && (w_last_idx == w_head_idx));
`else
    assign w_coal = 1'b0;
`endif

    assign w_aligned     = is_aligned(i_st_size, i_st_addr[1:0]);
    assign o_st_misalign = i_st_valid && !w_aligned;
    assign o_st_ready    = !w_full || w_coal;
    assign w_push        = i_st_valid && o_st_ready && w_aligned;
    assign w_alloc       = w_push && !w_coal;
    assign w_merge       = w_push && w_coal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
            for (int i = 0; i < N_ENTRIES; i++) r_q[i] <= '0;
        end else begin
            if (w_pop) begin
                r_q[w_head_idx].valid <= 1'b0;
                r_head                <= r_head + PTR_ONE;
            end
            if (w_alloc) begin
                r_q[w_tail_idx] <= '{valid: 1'b1, word_addr: w_st_waddr,
                                     mask: w_st_mask, data: w_st_lanes};
                r_tail          <= r_tail + PTR_ONE;
            end
            if (w_merge) begin
                r_q[w_last_idx].mask <= r_q[w_last_idx].mask | w_st_mask;
                r_q[w_last_idx].data <= w_merged;
            end
        end
    end

    for (genvar k = 0; k < N_ENTRIES; k++) begin : g_ord
        logic [PTR_W-1:0] w_idx;
        assign w_idx          = w_last_idx - PTR_W'(k);
        assign w_ord_match[k] = r_q[w_idx].valid && (r_q[w_idx].word_addr == w_ld_waddr);
        assign w_ord_mask[k]  = r_q[w_idx].mask;
        assign w_ord_data[k]  = r_q[w_idx].data;
    end

    dmem_store_queue_fwd_sel #(
        .N_ENTRIES  (N_ENTRIES),
        .NB         (NB),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fwd_sel (
        .i_match (w_ord_match),
        .i_mask  (w_ord_mask),
        .i_data  (w_ord_data),
        .o_found (w_found),
        .o_data  (w_fwd_data)
    );

    assign w_cov        = w_found & w_ld_mask;
    assign w_all        = (w_ld_mask != '0) && (w_cov == w_ld_mask);
    assign o_ld_hit     = i_ld_valid && w_all;
    assign o_ld_partial = i_ld_valid && (w_cov != '0) && !w_all;
    assign o_ld_data    = o_ld_hit ? ((w_fwd_data & w_ld_bits) >> {w_ld_off, 3'b000}) : '0;

    assign o_dr_addr = o_dr_valid ? {r_q[w_head_idx].word_addr, {OFF_W{1'b0}}} : '0;
    assign o_dr_mask = o_dr_valid ? r_q[w_head_idx].mask : '0;
    assign o_dr_data = o_dr_valid ? r_q[w_head_idx].data : '0;
    assign o_count   = w_count;
    assign o_full    = w_full;
    assign o_empty   = w_empty;

endmodule

// File: tb/tb_dmem_store_queue.sv
// Directed bench for dmem_store_queue: drain traffic is checked by a scoreboard monitor,
// status and forwarding outputs by direct compares against hand-computed values.
module tb_dmem_store_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_st_valid, i_ld_valid, i_dr_ready;
    logic [31:0] i_st_addr, i_st_data, i_ld_addr;
    logic [1:0]  i_st_size, i_ld_size;
    logic        o_st_ready, o_st_misalign, o_ld_hit, o_ld_partial;
    logic [31:0] o_ld_data, o_dr_addr, o_dr_data;
    logic        o_dr_valid, o_full, o_empty;
    logic [3:0]  o_dr_mask;
    logic [2:0]  o_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } drain_t;

    drain_t sb[$];
    drain_t mon_e;

    dmem_store_queue #(.N_ENTRIES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_st_valid    (i_st_valid),
        .i_st_addr     (i_st_addr),
        .i_st_size     (i_st_size),
        .i_st_data     (i_st_data),
        .o_st_ready    (o_st_ready),
        .o_st_misalign (o_st_misalign),
        .i_ld_valid    (i_ld_valid),
        .i_ld_addr     (i_ld_addr),
        .i_ld_size     (i_ld_size),
        .o_ld_hit      (o_ld_hit),
        .o_ld_partial  (o_ld_partial),
        .o_ld_data     (o_ld_data),
        .o_dr_valid    (o_dr_valid),
        .o_dr_addr     (o_dr_addr),
        .o_dr_mask     (o_dr_mask),
        .o_dr_data     (o_dr_data),
        .i_dr_ready    (i_dr_ready),
        .o_count       (o_count),
        .o_full        (o_full),
        .o_empty       (o_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted drain beat must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && o_dr_valid && i_dr_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL drain_unexpected: got addr 0x%08h expected no drain", o_dr_addr);
            end else begin
                mon_e = sb.pop_front();
                check("drain_addr", o_dr_addr, mon_e.addr);
                check("drain_mask", {28'b0, o_dr_mask}, {28'b0, mon_e.mask});
                check("drain_data", o_dr_data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within budget");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        i_st_valid = 1'b1;
        i_st_addr  = a;
        i_st_size  = sz;
        i_st_data  = d;
        cyc();
        i_st_valid = 1'b0;
    endtask

    task automatic load_chk(input string name, input logic [31:0] a, input logic [1:0] sz,
                            input logic eh, input logic ep, input logic [31:0] ed);
        i_ld_valid = 1'b1;
        i_ld_addr  = a;
        i_ld_size  = sz;
        @(negedge clk);
        check({name, "_hit"},     {31'b0, o_ld_hit},     {31'b0, eh});
        check({name, "_partial"}, {31'b0, o_ld_partial}, {31'b0, ep});
        check({name, "_data"},    o_ld_data, ed);
        cyc();
        i_ld_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        i_dr_ready = 1'b1;
        repeat (n) cyc();
        i_dr_ready = 1'b0;
    endtask

    task automatic expect_drain(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        drain_t e;
        e.addr = a;
        e.mask = m;
        e.data = d;
        sb.push_back(e);
    endtask

    initial begin
        i_st_valid = 0; i_st_addr = 0; i_st_size = 0; i_st_data = 0;
        i_ld_valid = 0; i_ld_addr = 0; i_ld_size = 0; i_dr_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_count",    {29'b0, o_count}, 32'd0);
        check("rst_empty",    {31'b0, o_empty}, 32'd1);
        check("rst_full",     {31'b0, o_full}, 32'd0);
        check("rst_st_ready", {31'b0, o_st_ready}, 32'd1);
        check("rst_misalign", {31'b0, o_st_misalign}, 32'd0);
        check("rst_dr_valid", {31'b0, o_dr_valid}, 32'd0);
        check("rst_dr_addr",  o_dr_addr, 32'd0);
        check("rst_ld_hit",   {31'b0, o_ld_hit}, 32'd0);
        check("rst_ld_data",  o_ld_data, 32'd0);
        cyc();

        // 1: reset mid-fill loses the queued stores
        store(32'h10, 2'd2, 32'h1);
        store(32'h14, 2'd2, 32'h2);
        store(32'h18, 2'd2, 32'h3);
        @(negedge clk);
        check("t1_count_before", {29'b0, o_count}, 32'd3);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("t1_async_count", {29'b0, o_count}, 32'd0);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("t1_count",    {29'b0, o_count}, 32'd0);
        check("t1_empty",    {31'b0, o_empty}, 32'd1);
        check("t1_dr_valid", {31'b0, o_dr_valid}, 32'd0);
        check("t1_st_ready", {31'b0, o_st_ready}, 32'd1);
        cyc();

        // 2: fill to full, fifth store refused, drain in order
        for (int i = 0; i < 4; i++) begin
            store(32'h100 + 32'(4 * i), 2'd2, 32'hA0 + 32'(i));
            expect_drain(32'h100 + 32'(4 * i), 4'hF, 32'hA0 + 32'(i));
        end
        @(negedge clk);
        check("t2_full",     {31'b0, o_full}, 32'd1);
        check("t2_st_ready", {31'b0, o_st_ready}, 32'd0);
        check("t2_count",    {29'b0, o_count}, 32'd4);
        cyc();
        i_st_valid = 1'b1; i_st_addr = 32'h110; i_st_size = 2'd2; i_st_data = 32'hBAD;
        @(negedge clk);
        check("t2_fifth_ready", {31'b0, o_st_ready}, 32'd0);
        cyc();
        i_st_valid = 1'b0;
        @(negedge clk);
        check("t2_fifth_count", {29'b0, o_count}, 32'd4);
        cyc();
        drain(4);
        @(negedge clk);
        check("t2_empty_after", {31'b0, o_empty}, 32'd1);
        cyc();

        // 3: byte forwarding, full and partial coverage
        store(32'h200, 2'd0, 32'hAA);
        expect_drain(32'h200, 4'b0001, 32'h000000AA);
        load_chk("t3_ldb",    32'h200, 2'd0, 1'b1, 1'b0, 32'h000000AA);
        load_chk("t3_ldw",    32'h200, 2'd2, 1'b0, 1'b1, 32'h0);
        load_chk("t3_ldb_ms", 32'h201, 2'd0, 1'b0, 1'b0, 32'h0);
        drain(1);

        // 4: youngest byte overrides older word
        store(32'h300, 2'd2, 32'h11223344);
        store(32'h301, 2'd0, 32'hFF);
        load_chk("t4_ldw", 32'h300, 2'd2, 1'b1, 1'b0, 32'h1122FF44);
        load_chk("t4_ldh", 32'h302, 2'd1, 1'b1, 1'b0, 32'h00001122);
`ifdef STQ_COALESCE_EN
        expect_drain(32'h300, 4'hF, 32'h1122FF44);
        @(negedge clk);
        check("t4_count", {29'b0, o_count}, 32'd1);
        cyc();
`else
        expect_drain(32'h300, 4'hF, 32'h11223344);
        expect_drain(32'h300, 4'b0010, 32'h0000FF00);
        @(negedge clk);
        check("t4_count", {29'b0, o_count}, 32'd2);
        cyc();
`endif
        drain(2);
        @(negedge clk);
        check("t4_empty_after", {31'b0, o_empty}, 32'd1);
        cyc();

        // 5: simultaneous push and pop, then misaligned store
        expect_drain(32'h400, 4'hF, 32'h1);
        expect_drain(32'h404, 4'hF, 32'h2);
        expect_drain(32'h408, 4'hF, 32'h3);
        store(32'h400, 2'd2, 32'h1);
        store(32'h404, 2'd2, 32'h2);
        i_st_valid = 1'b1; i_st_addr = 32'h408; i_st_size = 2'd2; i_st_data = 32'h3;
        i_dr_ready = 1'b1;
        @(negedge clk);
        check("t5_count_pre",  {29'b0, o_count}, 32'd2);
        check("t5_misalign_0", {31'b0, o_st_misalign}, 32'd0);
        cyc();
        i_st_valid = 1'b0;
        i_dr_ready = 1'b0;
        @(negedge clk);
        check("t5_count_post", {29'b0, o_count}, 32'd2);
        check("t5_head",       o_dr_addr, 32'h404);
        cyc();
        i_st_valid = 1'b1; i_st_addr = 32'h402; i_st_size = 2'd2; i_st_data = 32'hDEAD;
        @(negedge clk);
        check("t5_misalign", {31'b0, o_st_misalign}, 32'd1);
        cyc();
        i_st_valid = 1'b0;
        @(negedge clk);
        check("t5_count_mis", {29'b0, o_count}, 32'd2);
        cyc();
        drain(2);
        @(negedge clk);
        check("t5_empty_after", {31'b0, o_empty}, 32'd1);
        cyc();

        // 6: adjacent byte stores to one word
        store(32'h500, 2'd0, 32'h11);
        store(32'h501, 2'd0, 32'h22);
        @(negedge clk);
`ifdef STQ_COALESCE_EN
        check("t6_count",   {29'b0, o_count}, 32'd1);
        check("t6_dr_mask", {28'b0, o_dr_mask}, 32'h3);
        check("t6_dr_data", o_dr_data, 32'h00002211);
        expect_drain(32'h500, 4'b0011, 32'h00002211);
`else
        check("t6_count",   {29'b0, o_count}, 32'd2);
        check("t6_dr_mask", {28'b0, o_dr_mask}, 32'h1);
        check("t6_dr_data", o_dr_data, 32'h00000011);
        expect_drain(32'h500, 4'b0001, 32'h00000011);
        expect_drain(32'h500, 4'b0010, 32'h00002200);
`endif
        cyc();
        drain(2);
        @(negedge clk);
        check("t6_empty_after", {31'b0, o_empty}, 32'd1);
        check("sb_remaining",   32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
